sprite_attr_sync: RTL and testbench

Clocked, parametrised bridge between the NIOS PIO ports and the sprite renderer. It receives per-object X, Y, state and type attributes over a 4-phase software handshake into a shadow bank. It commits the shadow bank to an active bank only at a frame boundary, so the renderer never sees a half-updated frame. It also reports protocol errors and overwritten (dropped) updates.

---
 rtl/sprite_comm_pkg.sv | 21 ++
 rtl/sprite_attr_slot.sv | 80 ++++++++
 rtl/sprite_attr_sync.sv | 153 +++++++++++++++
 tb/tb_sprite_attr_sync.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_comm_pkg.sv
// Shared types and constants for the NIOS PIO to sprite renderer bridge.
//   sig_code_t : software command codes carried on to_hw_sig / to_sw_sig
//   hs_state_t : 4-phase handshake FSM states
//   DROP_MAX   : saturation value of the dropped-update counter
package sprite_comm_pkg;

  typedef enum logic [1:0] {
    SIG_IDLE = 2'd0,
    SIG_X    = 2'd1,
    SIG_Y    = 2'd2,
    SIG_ST   = 2'd3
  } sig_code_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } hs_state_t;

  localparam logic [7:0] DROP_MAX = 8'd255;

endpackage

// File: rtl/sprite_attr_slot.sv
// One object slot: shadow registers written by the handshake, active registers
// loaded from the shadow on commit.
//   clk, reset        : clock, asynchronous active-high reset
//   x_data, attr_data : write data for this slot (already sliced from the PIO word)
//   wr_x, wr_y, wr_st : shadow field write enables
//   commit            : copy shadow bank into active bank
//   x_out .. type_out : active-bank fields
module sprite_attr_slot
  import sprite_comm_pkg::*;
#(
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned STATE_W  = 3,
  parameter int unsigned TYPE_W   = 3,
  parameter int unsigned SCREEN_H = 480,
  parameter bit          FLIP_Y   = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [COORD_W-1:0]          x_data,
  input  logic [STATE_W+TYPE_W-1:0]   attr_data,
  input  logic                        wr_x,
  input  logic                        wr_y,
  input  logic                        wr_st,
  input  logic                        commit,
  output logic [COORD_W-1:0]          x_out,
  output logic [COORD_W-1:0]          y_out,
  output logic [STATE_W-1:0]          state_out,
  output logic [TYPE_W-1:0]           type_out
);

  localparam logic [COORD_W:0] ScreenH = (COORD_W + 1)'(SCREEN_H);

  logic [COORD_W-1:0] x_sh, y_sh;
  logic [STATE_W-1:0] state_sh;
  logic [TYPE_W-1:0]  type_sh;

  logic [COORD_W:0]   y_diff;
  logic [COORD_W-1:0] y_wr;

  // Extra bit catches a negative result (data above screen height) -> clamp to 0.
  always_comb begin
    y_diff = ScreenH - {1'b0, x_data};
    y_wr   = x_data;
    if (FLIP_Y) begin
      y_wr = y_diff[COORD_W] ? '0 : y_diff[COORD_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_sh     <= '0;
      y_sh     <= '0;
      state_sh <= '0;
      type_sh  <= '0;
    end else begin
      if (wr_x) x_sh <= x_data;
      if (wr_y) y_sh <= y_wr;
      if (wr_st) begin
        state_sh <= attr_data[STATE_W-1:0];
        type_sh  <= attr_data[STATE_W+TYPE_W-1:STATE_W];
      end
    end
  end

  // Commit samples the pre-edge shadow, so a same-cycle write lands next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_out     <= '0;
      y_out     <= '0;
      state_out <= '0;
      type_out  <= '0;
    end else if (commit) begin
      x_out     <= x_sh;
      y_out     <= y_sh;
      state_out <= state_sh;
      type_out  <= type_sh;
    end
  end

endmodule

// File: rtl/sprite_attr_sync.sv
// Bridge between NIOS PIO ports and the sprite renderer. Software writes
// X / Y / state+type into a shadow bank over a 4-phase handshake; the shadow
// bank is committed to the active bank on frame_start when an update is pending.
//   clk, reset   : clock, asynchronous active-high reset
//   to_hw_data   : per-slot 32-bit words from software
//   to_hw_sig    : command (0 idle, 1 X, 2 Y, 3 state/type + commit request)
//   to_sw_sig    : acknowledge, echoes command while acking
//   frame_start  : vertical-blank pulse
//   x_out .. type_out : active-bank attributes, slot i at [W*i +: W]
//   frame_valid  : set by the first commit
//   proto_err    : sticky, code changed without returning to idle
//   drop_count   : saturating count of pending sets overwritten before commit
module sprite_attr_sync
  import sprite_comm_pkg::*;
#(
  parameter int unsigned NUM_OBJ  = 16,
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned STATE_W  = 3,
  parameter int unsigned TYPE_W   = 3,
  parameter int unsigned SCREEN_H = 480
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_OBJ*32-1:0]        to_hw_data,
  input  logic [1:0]                   to_hw_sig,
  output logic [1:0]                   to_sw_sig,
  input  logic                         frame_start,
  output logic [NUM_OBJ*COORD_W-1:0]   x_out,
  output logic [NUM_OBJ*COORD_W-1:0]   y_out,
  output logic [NUM_OBJ*STATE_W-1:0]   state_out,
  output logic [NUM_OBJ*TYPE_W-1:0]    type_out,
  output logic                         frame_valid,
  output logic                         proto_err,
  output logic [7:0]                   drop_count
);

  sig_code_t             sig_q;
  logic [NUM_OBJ*32-1:0] data_q;

  hs_state_t  state_q, state_d;
  logic [1:0] ack_q, ack_d;
  logic       err_set;
  logic       wr_x, wr_y, wr_st;

  logic       pending_q, pending_d;
  logic [7:0] drop_q, drop_d;
  logic       fvalid_q;
  logic       perr_q;
  logic       commit;

  // Only the low field bits of each word are consumed.
  logic unused_data;
  assign unused_data = ^data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_q  <= SIG_IDLE;
      data_q <= '0;
    end else begin
      sig_q  <= sig_code_t'(to_hw_sig);
      data_q <= to_hw_data;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    err_set = 1'b0;
    wr_x    = 1'b0;
    wr_y    = 1'b0;
    wr_st   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sig_q != SIG_IDLE) begin
          wr_x    = (sig_q == SIG_X);
          wr_y    = (sig_q == SIG_Y);
          wr_st   = (sig_q == SIG_ST);
          ack_d   = sig_q;
          state_d = ACK;
        end
      end
      ACK: begin
        if (sig_q == SIG_IDLE) begin
          ack_d   = 2'd0;
          state_d = IDLE;
        end else if (sig_q != ack_q) begin
          err_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A code-3 write coinciding with a commit re-arms pending without counting a
  // drop: the previous set was just committed, not overwritten.
  always_comb begin
    commit    = frame_start && pending_q;
    pending_d = pending_q;
    drop_d    = drop_q;
    if (commit) pending_d = 1'b0;
    if (wr_st) begin
      pending_d = 1'b1;
      if (pending_q && !commit && drop_q != DROP_MAX) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ack_q     <= 2'd0;
      pending_q <= 1'b0;
      drop_q    <= 8'd0;
      fvalid_q  <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      if (commit)  fvalid_q <= 1'b1;
      if (err_set) perr_q   <= 1'b1;
    end
  end

  assign to_sw_sig   = ack_q;
  assign frame_valid = fvalid_q;
  assign proto_err   = perr_q;
  assign drop_count  = drop_q;

  for (genvar i = 0; i < NUM_OBJ; i++) begin : g_slot
    sprite_attr_slot #(
      .COORD_W  (COORD_W),
      .STATE_W  (STATE_W),
      .TYPE_W   (TYPE_W),
      .SCREEN_H (SCREEN_H),
      .FLIP_Y   (i != 0)  // slot 0 is the player cursor, kept unflipped
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .x_data    (data_q[32*i +: COORD_W]),
      .attr_data (data_q[32*i +: STATE_W+TYPE_W]),
      .wr_x      (wr_x),
      .wr_y      (wr_y),
      .wr_st     (wr_st),
      .commit    (commit),
      .x_out     (x_out[COORD_W*i +: COORD_W]),
      .y_out     (y_out[COORD_W*i +: COORD_W]),
      .state_out (state_out[STATE_W*i +: STATE_W]),
      .type_out  (type_out[TYPE_W*i +: TYPE_W])
    );
  end

endmodule

// File: tb/tb_sprite_attr_sync.sv
module tb_sprite_attr_sync;

  localparam int NUM_OBJ = 16;
  localparam int DW      = NUM_OBJ * 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [DW-1:0]     to_hw_data;
  logic [1:0]        to_hw_sig;
  logic [1:0]        to_sw_sig;
  logic              frame_start;
  logic [NUM_OBJ*10-1:0] x_out, y_out;
  logic [NUM_OBJ*3-1:0]  state_out, type_out;
  logic              frame_valid, proto_err;
  logic [7:0]        drop_count;

  int checks = 0;
  int errors = 0;

  sprite_attr_sync dut (
    .clk         (clk),
    .reset       (reset),
    .to_hw_data  (to_hw_data),
    .to_hw_sig   (to_hw_sig),
    .to_sw_sig   (to_sw_sig),
    .frame_start (frame_start),
    .x_out       (x_out),
    .y_out       (y_out),
    .state_out   (state_out),
    .type_out    (type_out),
    .frame_valid (frame_valid),
    .proto_err   (proto_err),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          slot;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [5:0]  st;
    logic [9:0]  exp_x;
    logic [9:0]  exp_y;
    logic [2:0]  exp_state;
    logic [2:0]  exp_type;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mk(input int s, input logic [31:0] v);
    logic [DW-1:0] d;
    d = '0;
    d[32*s +: 32] = v;
    return d;
  endfunction

  // Full 4-phase handshake with exact 2-edge ack latency checked both ways.
  task automatic hs(input logic [1:0] code, input logic [DW-1:0] d);
    to_hw_data = d;
    to_hw_sig  = code;
    tick();
    chk("ack_lat1", int'(to_sw_sig), 0);
    tick();
    chk("ack", int'(to_sw_sig), int'(code));
    to_hw_sig = 2'd0;
    tick();
    chk("drop_lat1", int'(to_sw_sig), int'(code));
    tick();
    chk("drop", int'(to_sw_sig), 0);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"}, int'(|x_out), 0);
    chk({tag, "_y"}, int'(|y_out), 0);
    chk({tag, "_st"}, int'(|state_out), 0);
    chk({tag, "_ty"}, int'(|type_out), 0);
    chk({tag, "_ack"}, int'(to_sw_sig), 0);
    chk({tag, "_fv"}, int'(frame_valid), 0);
    chk({tag, "_perr"}, int'(proto_err), 0);
    chk({tag, "_drop"}, int'(drop_count), 0);
  endtask

  initial begin
    vecs[0] = '{slot: 3,  x: 10'd100,  y: 10'd80,  st: 6'b010_101,
                exp_x: 10'd100,  exp_y: 10'd400, exp_state: 3'd5, exp_type: 3'd2};
    vecs[1] = '{slot: 1,  x: 10'd7,    y: 10'd500, st: 6'b001_001,
                exp_x: 10'd7,    exp_y: 10'd0,   exp_state: 3'd1, exp_type: 3'd1};
    vecs[2] = '{slot: 0,  x: 10'd320,  y: 10'd500, st: 6'b100_011,
                exp_x: 10'd320,  exp_y: 10'd500, exp_state: 3'd3, exp_type: 3'd4};
    vecs[3] = '{slot: 15, x: 10'd1023, y: 10'd480, st: 6'b111_000,
                exp_x: 10'd1023, exp_y: 10'd0,   exp_state: 3'd0, exp_type: 3'd7};
    vecs[4] = '{slot: 7,  x: 10'd0,    y: 10'd0,   st: 6'b000_111,
                exp_x: 10'd0,    exp_y: 10'd480, exp_state: 3'd7, exp_type: 3'd0};
    vecs[5] = '{slot: 2,  x: 10'd512,  y: 10'd479, st: 6'b011_110,
                exp_x: 10'd512,  exp_y: 10'd1,   exp_state: 3'd6, exp_type: 3'd3};

    reset       = 1'b1;
    to_hw_data  = '0;
    to_hw_sig   = 2'd0;
    frame_start = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk_all_zero("rst");

    // frame_start with nothing pending must not commit
    frame();
    chk("idle_frame_x", int'(|x_out), 0);
    chk("idle_frame_fv", int'(frame_valid), 0);

    for (int i = 0; i < 6; i++) begin
      int s;
      s = vecs[i].slot;
      hs(2'd1, mk(s, {22'd0, vecs[i].x}));
      hs(2'd2, mk(s, {22'd0, vecs[i].y}));
      hs(2'd3, mk(s, {26'd0, vecs[i].st}));
      if (i == 0) begin
        chk("precommit_x3", int'(x_out[30 +: 10]), 0);
        chk("precommit_fv", int'(frame_valid), 0);
      end
      frame();
      chk("vec_x", int'(x_out[10*s +: 10]), int'(vecs[i].exp_x));
      chk("vec_y", int'(y_out[10*s +: 10]), int'(vecs[i].exp_y));
      chk("vec_state", int'(state_out[3*s +: 3]), int'(vecs[i].exp_state));
      chk("vec_type", int'(type_out[3*s +: 3]), int'(vecs[i].exp_type));
      chk("vec_fv", int'(frame_valid), 1);
      chk("vec_drop", int'(drop_count), 0);
    end

    // Dropped update: second set overwrites the first before commit
    hs(2'd3, mk(4, 32'h0000_0011));
    hs(2'd3, mk(4, 32'h0000_0026));
    frame();
    chk("drop_one", int'(drop_count), 1);
    chk("drop_state", int'(state_out[12 +: 3]), 6);
    chk("drop_type", int'(type_out[12 +: 3]), 4);

    for (int i = 0; i < 300; i++) hs(2'd3, mk(4, 32'h0000_0009));
    chk("drop_sat", int'(drop_count), 255);

    // Protocol error: code 1 then code 2 without returning to idle
    to_hw_data = mk(3, 32'd55);
    to_hw_sig  = 2'd1;
    tick();
    tick();
    chk("perr_ack1", int'(to_sw_sig), 1);
    to_hw_data = mk(3, 32'd200);
    to_hw_sig  = 2'd2;
    repeat (3) tick();
    chk("perr_flag", int'(proto_err), 1);
    chk("perr_hold_ack", int'(to_sw_sig), 1);
    to_hw_sig = 2'd0;
    tick();
    tick();
    chk("perr_release", int'(to_sw_sig), 0);
    frame();
    chk("perr_x3", int'(x_out[30 +: 10]), 55);
    // Last Y write put zero in slot 3, flipped to 480; the code-2 attempt must not land
    chk("perr_y3", int'(y_out[30 +: 10]), 480);
    chk("perr_sticky", int'(proto_err), 1);

    // Reset clears everything, then simultaneous write + commit
    reset = 1'b1;
    #2;
    chk_all_zero("rst2");
    tick();
    reset = 1'b0;
    tick();
    hs(2'd3, mk(3, 32'b001_010));
    to_hw_data = mk(3, 32'b110_011);
    to_hw_sig  = 2'd3;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("sim_ack", int'(to_sw_sig), 3);
    chk("sim_state_old", int'(state_out[9 +: 3]), 2);
    chk("sim_type_old", int'(type_out[9 +: 3]), 1);
    chk("sim_fv", int'(frame_valid), 1);
    chk("sim_drop", int'(drop_count), 0);
    to_hw_sig = 2'd0;
    tick();
    tick();
    chk("sim_release", int'(to_sw_sig), 0);
    frame();
    chk("sim_state_new", int'(state_out[9 +: 3]), 3);
    chk("sim_type_new", int'(type_out[9 +: 3]), 6);
    chk("sim_drop_after", int'(drop_count), 0);

    // Reset while in ACK
    to_hw_data = mk(5, 32'd77);
    to_hw_sig  = 2'd1;
    tick();
    tick();
    chk("ackrst_pre", int'(to_sw_sig), 1);
    reset     = 1'b1;
    to_hw_sig = 2'd0;
    tick();
    chk_all_zero("ackrst");
    reset = 1'b0;
    tick();
    // FSM must be back in IDLE: a fresh code acks normally without error
    hs(2'd2, mk(5, 32'd100));
    chk("ackrst_noerr", int'(proto_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
